// File: rtl/onctl_latch_multi.sv
// Multi-channel ONCTL_N override latch. A debounced power-button press that lines up with an
// ONCTL_N rising edge holds ONCTL_N low until SLP_S3_N asserts or the watchdog expires.
module onctl_latch_multi #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned T_TIMEOUT = 40000000,
    parameter int unsigned DEB_CYC   = 4,
    parameter int unsigned REL_S3    = 1
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [NUM_CH-1:0]   iOnctl_n,
    input  logic [NUM_CH-1:0]   iSlps3_n,
    input  logic [NUM_CH-1:0]   iPwrbtn_n,
    input  logic [NUM_CH-1:0]   iClrTimeout,
    output logic [NUM_CH-1:0]   oOnctl_n_latch,
    output logic [NUM_CH-1:0]   oLatchActive,
    output logic [NUM_CH-1:0]   oTimeoutSticky,
    output logic [2*NUM_CH-1:0] oDbgState
);

    localparam int unsigned         DEB_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DEB_W-1:0]    DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0]    WDOG_LIM = CNT_W'(T_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LATCHED = 2'd1,
        ST_REARM   = 2'd2
    } state_t;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic             onctl_ff;
        logic             pwrbtn_deb;
        logic [DEB_W-1:0] deb_cnt;
        logic [CNT_W-1:0] wdog;
        logic             latch_q;
        logic             sticky_q;
        logic             trigger;
        logic             rel_s3;
        logic             rel_wdog;
        state_t           state;

        // Trigger compares the already-registered output with the live input: that is the rising edge
        // of ONCTL_N as the sequencer sees it.
        always_comb begin
            trigger  = ~latch_q & iOnctl_n[ch] & ~pwrbtn_deb;
            rel_s3   = (REL_S3 != 0) && !iSlps3_n[ch];
            rel_wdog = (wdog == WDOG_LIM);
        end

        always_ff @(posedge iClk) begin
            if (iRst) begin
                onctl_ff <= 1'b1;
            end else begin
                onctl_ff <= iOnctl_n[ch];
            end
        end

        // The filtered button only moves once the raw level has disagreed for DEB_CYC straight cycles.
        always_ff @(posedge iClk) begin
            if (iRst) begin
                pwrbtn_deb <= 1'b1;
                deb_cnt    <= '0;
            end else if (iPwrbtn_n[ch] == pwrbtn_deb) begin
                deb_cnt    <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                pwrbtn_deb <= iPwrbtn_n[ch];
                deb_cnt    <= '0;
            end else begin
                deb_cnt    <= deb_cnt + 1'b1;
            end
        end

        always_ff @(posedge iClk) begin
            if (iRst) begin
                state    <= ST_IDLE;
                latch_q  <= 1'b1;
                wdog     <= '0;
                sticky_q <= 1'b0;
            end else begin
                // A watchdog set further down overrides this clear.
                if (iClrTimeout[ch]) begin
                    sticky_q <= 1'b0;
                end
                case (state)
                    ST_IDLE: begin
                        if (trigger) begin
                            state   <= ST_LATCHED;
                            latch_q <= 1'b0;
                            wdog    <= '0;
                        end else begin
                            latch_q <= onctl_ff;
                        end
                    end
                    ST_LATCHED: begin
                        if (rel_s3) begin
                            state   <= ST_REARM;
                            wdog    <= '0;
                            latch_q <= onctl_ff;
                        end else if (rel_wdog) begin
                            state    <= ST_REARM;
                            wdog     <= '0;
                            latch_q  <= onctl_ff;
                            sticky_q <= 1'b1;
                        end else begin
                            latch_q <= 1'b0;
                            wdog    <= wdog + 1'b1;
                        end
                    end
                    ST_REARM: begin
                        // Wait for the button to be let go so a held button cannot re-latch at once.
                        latch_q <= onctl_ff;
                        if (pwrbtn_deb) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        latch_q <= 1'b1;
                        wdog    <= '0;
                    end
                endcase
            end
        end

        assign oOnctl_n_latch[ch]     = latch_q;
        assign oTimeoutSticky[ch]     = sticky_q;
        assign oLatchActive[ch]       = (state == ST_LATCHED);
        assign oDbgState[2*ch +: 2]   = state;
    end

endmodule

// File: tb/tb_onctl_latch_multi.sv
// Bench for onctl_latch_multi: directed sequences, a cycle-level behavioural model feeding an
// expected queue, and literal spot checks at the interesting points.
module tb_onctl_latch_multi;

    localparam int NUM_CH    = 2;
    localparam int CNT_W     = 32;
    localparam int T_TIMEOUT = 100;
    localparam int DEB_CYC   = 4;
    localparam int REL_S3    = 1;
    localparam int VW        = 3 * NUM_CH;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_CH-1:0]   onctl_n  = '1;
    logic [NUM_CH-1:0]   slps3_n  = '1;
    logic [NUM_CH-1:0]   pwrbtn_n = '1;
    logic [NUM_CH-1:0]   clr      = '0;
    logic [NUM_CH-1:0]   latch_out;
    logic [NUM_CH-1:0]   active;
    logic [NUM_CH-1:0]   sticky;
    logic [2*NUM_CH-1:0] dbg_state;

    onctl_latch_multi #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .T_TIMEOUT(T_TIMEOUT),
        .DEB_CYC(DEB_CYC), .REL_S3(REL_S3)
    ) dut (
        .iClk(clk),
        .iRst(rst),
        .iOnctl_n(onctl_n),
        .iSlps3_n(slps3_n),
        .iPwrbtn_n(pwrbtn_n),
        .iClrTimeout(clr),
        .oOnctl_n_latch(latch_out),
        .oLatchActive(active),
        .oTimeoutSticky(sticky),
        .oDbgState(dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model: mode 0 idle, 1 holding, 2 waiting for button release
    int   cyc = 0;
    int   m_mode [NUM_CH];
    int   m_entry[NUM_CH];
    int   m_run  [NUM_CH];
    logic m_out  [NUM_CH];
    logic m_stk  [NUM_CH];
    logic m_prev [NUM_CH];
    logic m_deb  [NUM_CH];
    logic [VW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input logic r, input logic [NUM_CH-1:0] on, input logic [NUM_CH-1:0] s3,
                              input logic [NUM_CH-1:0] pb, input logic [NUM_CH-1:0] cl);
        logic [NUM_CH-1:0] e_out, e_act, e_stk;
        cyc++;
        for (int c = 0; c < NUM_CH; c++) begin
            logic nout;
            logic tmo;
            tmo = 1'b0;
            if (r) begin
                m_mode[c] = 0; m_out[c] = 1'b1; m_stk[c] = 1'b0;
                m_prev[c] = 1'b1; m_deb[c] = 1'b1; m_run[c] = 0;
            end else begin
                nout = m_prev[c];
                if (m_mode[c] == 0) begin
                    if (!m_out[c] && on[c] && !m_deb[c]) begin
                        m_mode[c] = 1; m_entry[c] = cyc; nout = 1'b0;
                    end
                end else if (m_mode[c] == 1) begin
                    if (REL_S3 != 0 && !s3[c]) begin
                        m_mode[c] = 2;
                    end else if (cyc - m_entry[c] == T_TIMEOUT + 1) begin
                        m_mode[c] = 2; tmo = 1'b1;
                    end else begin
                        nout = 1'b0;
                    end
                end else if (m_deb[c]) begin
                    m_mode[c] = 0;
                end
                if (tmo) m_stk[c] = 1'b1;
                else if (cl[c]) m_stk[c] = 1'b0;
                if (pb[c] == m_deb[c]) begin
                    m_run[c] = 0;
                end else begin
                    m_run[c]++;
                    if (m_run[c] == DEB_CYC) begin
                        m_deb[c] = pb[c];
                        m_run[c] = 0;
                    end
                end
                m_prev[c] = on[c];
                m_out[c]  = nout;
            end
            e_out[c] = m_out[c];
            e_act[c] = (m_mode[c] == 1);
            e_stk[c] = m_stk[c];
        end
        exp_q.push_back({e_out, e_act, e_stk});
    endtask

    // driver: one clock per iteration, model updated with the inputs the DUT sampled, then compared
    task automatic tick(input int n = 1);
        repeat (n) begin
            logic              r;
            logic [NUM_CH-1:0] on, s3, pb, cl;
            logic [VW-1:0]     exp;
            r = rst; on = onctl_n; s3 = slps3_n; pb = pwrbtn_n; cl = clr;
            @(posedge clk);
            model_step(r, on, s3, pb, cl);
            #1;
            exp = exp_q.pop_front();
            check("model_outputs", {latch_out, active, sticky}, exp);
        end
    endtask

    // drive ONCTL_N low on the given channels, debounce the button low, then raise ONCTL_N
    task automatic do_latch(input logic [NUM_CH-1:0] chans);
        onctl_n  = ~chans;
        tick(2);
        pwrbtn_n = ~chans;
        tick(6);
        onctl_n  = '1;
        tick(1);
    endtask

    initial begin
        rst = 1'b1;
        tick(2);
        check("reset_latch", latch_out, 2'b11);
        check("reset_active", active, 2'b00);
        check("reset_sticky", sticky, 2'b00);
        rst = 1'b0;

        // pass-through with two-cycle latency
        onctl_n = 2'b10;
        tick(1);
        check("pass_lat1", latch_out, 2'b11);
        tick(1);
        check("pass_lat2", latch_out, 2'b10);
        onctl_n = 2'b11;
        tick(2);
        check("pass_rise", latch_out, 2'b11);
        check("pass_no_latch", active, 2'b00);

        // latch then release by SLP_S3_N
        do_latch(2'b01);
        check("latch_active", active, 2'b01);
        check("latch_no_glitch", latch_out, 2'b10);
        tick(20);
        check("latch_hold", latch_out, 2'b10);
        slps3_n = 2'b10;
        tick(1);
        check("s3_release_out", latch_out, 2'b11);
        check("s3_release_act", active, 2'b00);
        check("s3_release_stk", sticky, 2'b00);
        slps3_n  = 2'b11;
        pwrbtn_n = 2'b11;
        tick(5);

        // watchdog release after exactly T_TIMEOUT+1 cycles
        do_latch(2'b01);
        tick(T_TIMEOUT);
        check("wdog_still_latched", active, 2'b01);
        tick(1);
        check("wdog_release_act", active, 2'b00);
        check("wdog_sticky", sticky, 2'b01);
        check("wdog_release_out", latch_out, 2'b11);

        // button still held: a fresh trigger is ignored
        onctl_n = 2'b10;
        tick(2);
        onctl_n = 2'b11;
        tick(2);
        check("rearm_no_latch", active, 2'b00);
        clr = 2'b01;
        tick(1);
        check("sticky_clear", sticky, 2'b00);
        clr = 2'b00;
        pwrbtn_n = 2'b11;
        tick(5);
        do_latch(2'b01);
        check("relatch_after_rearm", active, 2'b01);
        slps3_n = 2'b10;
        tick(1);
        slps3_n  = 2'b11;
        pwrbtn_n = 2'b11;
        tick(5);

        // 3-cycle button pulse is too short to count
        onctl_n = 2'b10;
        tick(2);
        pwrbtn_n = 2'b10;
        tick(2);
        onctl_n = 2'b11;
        tick(1);
        pwrbtn_n = 2'b11;
        tick(3);
        check("short_pulse_no_latch", active, 2'b00);

        // two channels latched, independent release, then reset mid-hold
        do_latch(2'b11);
        check("dual_latch", active, 2'b11);
        tick(10);
        slps3_n = 2'b01;
        tick(1);
        check("ch1_release_only", active, 2'b01);
        slps3_n = 2'b11;
        tick(5);
        check("ch0_still_latched", active, 2'b01);
        rst = 1'b1;
        tick(1);
        check("midrst_latch", latch_out, 2'b11);
        check("midrst_active", active, 2'b00);
        check("midrst_sticky", sticky, 2'b00);
        rst = 1'b0;
        pwrbtn_n = 2'b11;
        tick(5);

        // SLP_S3_N on the very cycle the watchdog expires wins
        do_latch(2'b01);
        tick(T_TIMEOUT);
        slps3_n = 2'b10;
        tick(1);
        check("tie_release_act", active, 2'b00);
        check("tie_no_sticky", sticky, 2'b00);
        slps3_n  = 2'b11;
        pwrbtn_n = 2'b11;
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
